// File: rtl/alu_op_sequencer_if.sv
// Interface between alu_op_sequencer and its environment.
// The sequencer uses the master modport. The ALU, the mux and the controlling
// logic use the slave modport.
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds the zero_flags signal.
interface alu_op_sequencer_if #(
    parameter int N = 4
);
    logic         start;
    logic [9:0]   op_mask;
    logic [N:0]   q_in;
    logic [3:0]   alu_control;
    logic         busy;
    logic         done;
    logic [9:0]   valid;
    logic [3:0]   rd_sel;
    logic [N:0]   rd_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic [9:0]   zero_flags;
`endif

    modport master (
        input  start, op_mask, q_in, rd_sel,
        output alu_control, busy, done, valid, rd_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , output zero_flags
`endif
    );

    modport slave (
        output start, op_mask, q_in, rd_sel,
        input  alu_control, busy, done, valid, rd_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , input zero_flags
`endif
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps the ALU result-mux select through the requested
// operation codes in ascending order. It holds each code for SETTLE cycles,
// then captures Q into a 10-entry result bank.
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds per-op zero flags (bus.zero_flags).
module alu_op_sequencer #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input logic              clk,
    input logic              rst,
    alu_op_sequencer_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam state_t     FIRST_ST    = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    state_t     state;
    state_t     state_nxt;
    logic [N:0] bank [10];
    logic [9:0] mask_r;
    logic [3:0] cnt;
    logic [3:0] first_idx;
    logic [3:0] next_idx;
    logic       has_first;
    logic       has_next;

    // Lowest requested code in the incoming mask, and the next requested code
    // above the current one in the latched mask.
    always_comb begin
        first_idx = '0;
        has_first = 1'b0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bus.op_mask[i] && !has_first) begin
                first_idx = 4'(i);
                has_first = 1'b1;
            end
            if (mask_r[i] && (4'(i) > bus.alu_control) && !has_next) begin
                next_idx = 4'(i);
                has_next = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = has_first ? FIRST_ST : ST_DONE;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt = has_next ? FIRST_ST : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        bus.busy = (state != ST_IDLE);
        bus.done = (state == ST_DONE);
    end

    // Select, counter, mask, bank and valid bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_control <= '0;
            bus.valid       <= '0;
            mask_r          <= '0;
            cnt             <= '0;
            for (int unsigned i = 0; i < 10; i++) bank[i] <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            bus.zero_flags  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bus.valid <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        bus.zero_flags <= '0;
`endif
                        if (has_first) begin
                            mask_r          <= bus.op_mask;
                            bus.alu_control <= first_idx;
                            cnt             <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt + 4'd1;
                end
                ST_CAPTURE: begin
                    bank[bus.alu_control]      <= bus.q_in;
                    bus.valid[bus.alu_control] <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    bus.zero_flags[bus.alu_control] <= (bus.q_in == '0);
`endif
                    if (has_next) begin
                        bus.alu_control <= next_idx;
                        cnt             <= '0;
                    end
                end
                ST_DONE: begin
                    bus.alu_control <= '0;
                end
                default: ;
            endcase
        end
    end

    // Combinational bank read port; out-of-range indices read as zero.
    always_comb begin
        bus.rd_data = (bus.rd_sel < 4'd10) ? bank[bus.rd_sel] : '0;
    end
endmodule
